pool_stream_tx: RTL

POOL_STREAM_TX -- requirements
Module: pool_stream_tx

---
 rtl/pool_stream_tx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pool_stream_tx.sv
// 2x2 stride-2 max pooling over a raster pixel stream, 12 signed 8-bit lanes.
// Optional macro POOL_RELU_EN clamps negative output lanes to zero.
module pool_stream_tx #(
    parameter int FM_W = 8,
    parameter int FM_H = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [95:0] i_conv_data,
    input  logic        i_conv_valid,
    output logic [95:0] o_pool_data_out,
    output logic        o_pool_valid_out,
    output logic        o_pool_end,
    output logic        o_busy
);

    localparam int CW  = (FM_W > 1) ? $clog2(FM_W) : 1;
    localparam int RW  = (FM_H > 1) ? $clog2(FM_H) : 1;
    localparam int LB  = FM_W / 2;
    localparam int LBW = (LB > 1) ? $clog2(LB) : 1;

    typedef enum logic {
        ROW_EVEN,
        ROW_ODD
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [95:0]     h_q;
    logic [95:0]     linebuf [LB];
    logic [LBW-1:0]  lb_idx;
    logic            col_last;
    logic            row_last;
    logic            lb_we;
    logic            out_we;
    logic [95:0]     hmax;
    logic [95:0]     pool_val;

    function automatic logic [95:0] vmax(input logic [95:0] a, input logic [95:0] b);
        logic [95:0] r;
        r = '0;
        for (int k = 0; k < 12; k++) begin
            r[8*k +: 8] = ($signed(a[8*k +: 8]) > $signed(b[8*k +: 8]))
                        ? a[8*k +: 8] : b[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [95:0] relu(input logic [95:0] a);
        logic [95:0] r;
        r = a;
        for (int k = 0; k < 12; k++) begin
            if (a[8*k+7]) r[8*k +: 8] = 8'h00;
        end
        return r;
    endfunction

    assign col_last = (col == CW'(FM_W - 1));
    assign row_last = (row == RW'(FM_H - 1));
    assign lb_idx   = LBW'(col >> 1);
    assign hmax     = vmax(h_q, i_conv_data);
    assign o_busy   = (col != '0) || (row != '0);

`ifdef POOL_RELU_EN
    assign pool_val = relu(vmax(linebuf[lb_idx], hmax));
`else
    assign pool_val = vmax(linebuf[lb_idx], hmax);
`endif

    // Row-parity FSM: next state and write strobes for line buffer / output.
    always_comb begin
        state_nx = state;
        lb_we    = 1'b0;
        out_we   = 1'b0;
        if (i_conv_valid) begin
            if (col_last) begin
                state_nx = (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
            end
            if (col[0]) begin
                lb_we  = (state == ROW_EVEN);
                out_we = (state == ROW_ODD);
            end
        end
    end

    // Counters, FSM, horizontal hold register and registered pooled output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ROW_EVEN;
            col              <= '0;
            row              <= '0;
            h_q              <= '0;
            o_pool_data_out  <= '0;
            o_pool_valid_out <= 1'b0;
            o_pool_end       <= 1'b0;
        end else begin
            state            <= state_nx;
            o_pool_valid_out <= out_we;
            o_pool_end       <= out_we && row_last && col_last;
            if (out_we) o_pool_data_out <= pool_val;
            if (i_conv_valid) begin
                if (!col[0]) h_q <= i_conv_data;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Line buffer of horizontal maxima from the even row; rewritten before every read.
    always_ff @(posedge i_clk) begin
        if (lb_we) linebuf[lb_idx] <= hmax;
    end

endmodule
